// File: rtl/cmd_resp_receiver_pkg.sv
// Shared definitions for the CMD-line response receiver: FSM encoding, frame
// geometry and the serial CRC7 step.
package cmd_resp_receiver_pkg;

    localparam int unsigned RespLenDefault = 48;
    localparam logic [6:0]  Crc7Poly       = 7'h09;

    // Bit positions counted from the LSB of the captured frame.
    localparam int unsigned CrcHiPos     = 7;
    localparam int unsigned CrcLoPos     = 1;
    localparam int unsigned EndBitPos    = 0;
    localparam int unsigned CrcDataLoPos = 8;
    // Transmission bit sits at RESP_LEN - TxBitOffset.
    localparam int unsigned TxBitOffset  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitStart,
        StReceive,
        StCheck,
        StDone
    } state_e;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
    endfunction

endpackage

// File: rtl/cmd_resp_receiver_crc7_serial.sv
// Bit-serial CRC7 (x^7 + x^3 + 1), MSB first, zero initial value.
module crc7_serial
    import cmd_resp_receiver_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_bit,
    output logic [6:0] crc
);

    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = crc7_step(crc_q, data_bit);
        end
    end

    always_ff @(posedge clock) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/cmd_resp_receiver.sv
// Receives one CMD-line response frame, checks CRC7 and framing bits, and
// holds the result until acknowledged.
module cmd_resp_receiver
    import cmd_resp_receiver_pkg::*;
#(
    parameter int unsigned RESP_LEN = RespLenDefault,
    parameter int unsigned TO_WIDTH = 8
) (
    input  logic                sd_clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                cmd_pin,
    input  logic [TO_WIDTH-1:0] timeout_limit,
    input  logic                ack_in,
    output logic [RESP_LEN-1:0] response,
    output logic                resp_valid,
    output logic                crc_err,
    output logic                frame_err,
    output logic                timeout,
    output logic                busy
);

    localparam int unsigned CntW = $clog2(RESP_LEN + 1);

    state_e              state_q, state_d;
    logic [RESP_LEN-1:0] response_q, response_d;
    logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [TO_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                resp_valid_q, resp_valid_d;
    logic                crc_err_q, crc_err_d;
    logic                frame_err_q, frame_err_d;
    logic                timeout_q, timeout_d;
    logic                crc_en, crc_clr;
    logic [6:0]          crc_val;

    crc7_serial u_crc7 (
        .clock    (sd_clock),
        .clear    (crc_clr),
        .enable   (crc_en),
        .data_bit (cmd_pin),
        .crc      (crc_val)
    );

    assign crc_clr = (state_q == StIdle) || !reset;

    always_comb begin
        state_d      = state_q;
        response_d   = response_q;
        bit_cnt_d    = bit_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        resp_valid_d = resp_valid_q;
        crc_err_d    = crc_err_q;
        frame_err_d  = frame_err_q;
        timeout_d    = timeout_q;
        crc_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                bit_cnt_d  = '0;
                if (enable) state_d = StWaitStart;
            end
            StWaitStart: begin
                // A start bit in the same cycle as the limit wins over the timeout.
                if (!cmd_pin) begin
                    response_d = RESP_LEN'(cmd_pin);
                    bit_cnt_d  = CntW'(1);
                    crc_en     = 1'b1;
                    state_d    = StReceive;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (timeout_limit != '0 && wait_cnt_d == timeout_limit) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StReceive: begin
                response_d = {response_q[RESP_LEN-2:0], cmd_pin};
                bit_cnt_d  = bit_cnt_q + 1'b1;
                crc_en     = bit_cnt_q < CntW'(RESP_LEN - CrcDataLoPos);
                if (bit_cnt_q == CntW'(RESP_LEN - 1)) state_d = StCheck;
            end
            StCheck: begin
                crc_err_d    = crc_val != response_q[CrcHiPos:CrcLoPos];
                frame_err_d  = response_q[RESP_LEN-TxBitOffset] | ~response_q[EndBitPos];
                resp_valid_d = 1'b1;
                state_d      = StDone;
            end
            StDone: begin
                if (ack_in) begin
                    resp_valid_d = 1'b0;
                    crc_err_d    = 1'b0;
                    frame_err_d  = 1'b0;
                    timeout_d    = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!enable && state_q != StIdle) begin
            state_d      = StIdle;
            resp_valid_d = 1'b0;
            crc_err_d    = 1'b0;
            frame_err_d  = 1'b0;
            timeout_d    = 1'b0;
        end
    end

    always_ff @(posedge sd_clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            response_q   <= '0;
            bit_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            crc_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            response_q   <= response_d;
            bit_cnt_q    <= bit_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            resp_valid_q <= resp_valid_d;
            crc_err_q    <= crc_err_d;
            frame_err_q  <= frame_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign response   = response_q;
    assign resp_valid = resp_valid_q;
    assign crc_err    = crc_err_q;
    assign frame_err  = frame_err_q;
    assign timeout    = timeout_q;
    assign busy       = state_q != StIdle;

endmodule

// File: tb/tb_cmd_resp_receiver.sv
// Directed bench for cmd_resp_receiver: table of frames plus hand-written
// timeout, abort and reset sequences.
module tb_cmd_resp_receiver;

    localparam int unsigned RL = 48;
    localparam int unsigned TW = 8;

    localparam logic [47:0] FrameR7   = 48'h08_0000_01AA_13;
    localparam logic [47:0] FrameCrc  = 48'h08_0000_01AA_15;
    localparam logic [47:0] FrameTx   = 48'h48_0000_01AA_13;
    localparam logic [47:0] FrameEnd  = 48'h08_0000_01AA_12;

    logic          clk = 1'b0;
    logic          rst_n, enable, cmd_pin, ack_in;
    logic [TW-1:0] to_lim;
    logic [RL-1:0] response;
    logic          resp_valid, crc_err, frame_err, timeout, busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [47:0] frame;
        logic        exp_crc;
        logic        exp_frm;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    cmd_resp_receiver #(
        .RESP_LEN (RL),
        .TO_WIDTH (TW)
    ) dut (
        .sd_clock      (clk),
        .reset         (rst_n),
        .enable        (enable),
        .cmd_pin       (cmd_pin),
        .timeout_limit (to_lim),
        .ack_in        (ack_in),
        .response      (response),
        .resp_valid    (resp_valid),
        .crc_err       (crc_err),
        .frame_err     (frame_err),
        .timeout       (timeout),
        .busy          (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One edge to leave IDLE, then n_idle high samples in WAIT_START.
    task automatic arm_wait(input int n_idle);
        cmd_pin = 1'b1;
        step();
        repeat (n_idle) step();
    endtask

    task automatic send_bits(input logic [47:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            cmd_pin = f[47-i];
            step();
        end
        cmd_pin = 1'b1;
    endtask

    task automatic expect_clean(input string tag, input logic [47:0] f);
        check({tag, "_valid"}, resp_valid, 1'b1);
        check({tag, "_resp"}, response, f);
        check({tag, "_flags"}, {crc_err, frame_err, timeout}, 3'b000);
    endtask

    initial begin
        logic saw_to;

        vecs[0] = '{frame: FrameR7,  exp_crc: 1'b0, exp_frm: 1'b0};
        vecs[1] = '{frame: FrameCrc, exp_crc: 1'b1, exp_frm: 1'b0};
        vecs[2] = '{frame: FrameTx,  exp_crc: 1'b1, exp_frm: 1'b1};
        vecs[3] = '{frame: FrameEnd, exp_crc: 1'b0, exp_frm: 1'b1};

        rst_n   = 1'b0;
        enable  = 1'b1;
        cmd_pin = 1'b1;
        ack_in  = 1'b1;
        to_lim  = '0;
        step();
        step();
        check("reset_resp", response, '0);
        check("reset_flags", {resp_valid, crc_err, frame_err, timeout, busy}, 5'b0);

        rst_n  = 1'b1;
        ack_in = 1'b0;

        for (int i = 0; i < 4; i++) begin
            arm_wait(5);
            if (i > 0) check($sformatf("v%0d_retain", i), response, vecs[i-1].frame);
            check($sformatf("v%0d_busy", i), busy, 1'b1);
            send_bits(vecs[i].frame, 48);
            check($sformatf("v%0d_valid_early", i), resp_valid, 1'b0);
            step();
            check($sformatf("v%0d_valid", i), resp_valid, 1'b1);
            check($sformatf("v%0d_resp", i), response, vecs[i].frame);
            check($sformatf("v%0d_crc", i), crc_err, vecs[i].exp_crc);
            check($sformatf("v%0d_frm", i), frame_err, vecs[i].exp_frm);
            check($sformatf("v%0d_to", i), timeout, 1'b0);
            step();
            step();
            check($sformatf("v%0d_hold", i), {resp_valid, crc_err, frame_err},
                  {1'b1, vecs[i].exp_crc, vecs[i].exp_frm});
            ack_in = 1'b1;
            step();
            ack_in = 1'b0;
            check($sformatf("v%0d_ack", i), {resp_valid, crc_err, frame_err, timeout, busy}, 5'b0);
            check($sformatf("v%0d_keep", i), response, vecs[i].frame);
        end

        // Timeout after exactly 8 WAIT_START samples.
        to_lim = 8'd8;
        arm_wait(0);
        repeat (7) step();
        check("to_early", {timeout, busy}, 2'b01);
        step();
        check("to_fire", {timeout, resp_valid}, 2'b10);
        step();
        check("to_hold", timeout, 1'b1);
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        check("to_ack", {timeout, busy}, 2'b00);

        // Start bit lands on the same edge the limit would be reached.
        to_lim = 8'd3;
        arm_wait(2);
        send_bits(FrameR7, 48);
        check("race_no_to", timeout, 1'b0);
        step();
        expect_clean("race", FrameR7);
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;

        // No timeout when the limit is zero.
        to_lim = '0;
        saw_to = 1'b0;
        arm_wait(0);
        repeat (300) begin
            step();
            if (timeout) saw_to = 1'b1;
        end
        check("to0_none", saw_to, 1'b0);
        check("to0_busy", busy, 1'b1);
        enable = 1'b0;
        step();
        check("to0_disable", busy, 1'b0);

        // Abort mid-frame, then re-arm for a clean capture.
        enable = 1'b1;
        arm_wait(5);
        send_bits(FrameTx, 20);
        enable = 1'b0;
        step();
        check("abort_idle", {resp_valid, crc_err, frame_err, timeout, busy}, 5'b0);
        enable = 1'b1;
        arm_wait(5);
        send_bits(FrameR7, 48);
        step();
        expect_clean("rearm", FrameR7);
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;

        // Disable while DONE holds an error result.
        arm_wait(1);
        send_bits(FrameCrc, 48);
        step();
        check("done_err", crc_err, 1'b1);
        enable = 1'b0;
        step();
        check("done_abort", {resp_valid, crc_err, frame_err, busy}, 4'b0);

        // Reset mid-frame with ack held during RECEIVE.
        enable = 1'b1;
        arm_wait(3);
        ack_in = 1'b1;
        send_bits(FrameR7, 20);
        check("ack_ignored", busy, 1'b1);
        rst_n = 1'b0;
        step();
        check("midrst_resp", response, '0);
        check("midrst_flags", {resp_valid, crc_err, frame_err, timeout, busy}, 5'b0);
        rst_n  = 1'b1;
        ack_in = 1'b0;
        arm_wait(5);
        send_bits(FrameR7, 48);
        step();
        expect_clean("post_rst", FrameR7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
